// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver slice.
//   ps2_state_t : receiver FSM encoding (IDLE, DATA, CHECK)
//   FRAME_BITS  : start + 8 data + parity + stop
//   DATA_BITS   : payload width
//   ps2_dbg_t   : FSM observation bundle exported on the interface
//   odd_parity_ok() : true when data plus parity bit hold an odd number of ones
package ps2_pkg;

   localparam int FRAME_BITS = 11;
   localparam int DATA_BITS  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      CHECK = 2'd2
   } ps2_state_t;

   typedef struct packed {
      ps2_state_t            state;
      logic [3:0]            bit_cnt;
      logic [FRAME_BITS-1:0] shreg;
   } ps2_dbg_t;

   function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_rx_checked_if.sv
// Receiver-side bus of the PS/2 receiver.
//   rx_en        : consumer permits the start of a new frame
//   dout         : last good data byte
//   rx_done_tick : one-cycle pulse, dout just updated
//   err_parity / err_frame / err_timeout : one-cycle error pulses
//   rx_busy      : receiver is inside a frame
//   dbg          : FSM state, remaining-bit counter and shift register
//
// Handshake: there is no backpressure. rx_done_tick is the valid strobe for
// dout and is never held; the consumer must take dout in that cycle or later
// (dout stays stable until the next good frame). At most one of the four
// pulses is high in any cycle.
interface ps2_rx_checked_if;
   import ps2_pkg::*;

   logic       rx_en;
   logic [7:0] dout;
   logic       rx_done_tick;
   logic       err_parity;
   logic       err_frame;
   logic       err_timeout;
   logic       rx_busy;
   ps2_dbg_t   dbg;

   modport master (
      input  rx_en,
      output dout, rx_done_tick, err_parity, err_frame, err_timeout, rx_busy, dbg
   );

   modport slave (
      output rx_en,
      input  dout, rx_done_tick, err_parity, err_frame, err_timeout, rx_busy, dbg
   );

endinterface

// File: rtl/ps2_clk_filter.sv
// Glitch filter and falling-edge detector for the PS/2 clock line.
//   clk, reset : system clock, synchronous active-high reset
//   ps_c       : raw PS/2 clock (asynchronous)
//   fall_tick  : high for the one cycle in which the filtered clock goes 1 -> 0
// The filtered clock only changes once FILTER_LEN consecutive samples agree,
// so pulses shorter than FILTER_LEN cycles are absorbed. The first stage of
// the shift register also serves as the input synchroniser.
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic ps_c,
   output logic fall_tick
);

   logic [FILTER_LEN-1:0] filt_reg;
   logic                  f_val;

   always_ff @(posedge clk) begin
      if (reset) begin
         filt_reg <= '1;
         f_val    <= 1'b1;
      end else begin
         filt_reg <= {ps_c, filt_reg[FILTER_LEN-1:1]};
         if (filt_reg == '1)
            f_val <= 1'b1;
         else if (filt_reg == '0)
            f_val <= 1'b0;
      end
   end

   // Asserted in the cycle whose clock edge drops f_val.
   assign fall_tick = f_val && (filt_reg == '0);

endmodule

// File: rtl/ps2_rx_checked.sv
// PS/2 device-to-host frame receiver with parity, framing and timeout checks.
//   clk, reset : system clock, synchronous active-high reset
//   ps_c, ps_d : PS/2 clock and data lines (asynchronous)
//   rx         : receiver bus (rx_en in; dout, pulses, rx_busy, dbg out)
// Frame: start 0, 8 data bits LSB first, odd parity, stop 1.
module ps2_rx_checked
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN   = 8,
   parameter int TIMEOUT_CYC  = 100000,
   parameter int CHECK_PARITY = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic ps_c,
   input  logic ps_d,
   ps2_rx_checked_if.master rx
);

   localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

   logic                  fall_tick;
   ps2_state_t            state;
   logic [3:0]            bit_cnt;
   logic [FRAME_BITS-1:0] shreg;
   logic [FRAME_BITS-1:0] nxt_shreg;
   logic [WD_W-1:0]       wdog;
   logic [7:0]            dout_r;
   logic                  done_r, perr_r, ferr_r, terr_r;
   logic                  stop_bit, parity_bad;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk       (clk),
      .reset     (reset),
      .ps_c      (ps_c),
      .fall_tick (fall_tick)
   );

   // ps_d is sampled only on fall_tick, which lags the real ps_c edge by the
   // filter length, so the data line has long settled by then.
   // After the final shift: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
   always_comb begin
      nxt_shreg  = {ps_d, shreg[FRAME_BITS-1:1]};
      stop_bit   = nxt_shreg[10];
      parity_bad = (CHECK_PARITY != 0) && !odd_parity_ok(nxt_shreg[8:1], nxt_shreg[9]);
   end

   // Verdict pulses are registered on the last fall tick so they are high
   // during the single CHECK cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         wdog    <= '0;
         dout_r  <= '0;
         done_r  <= 1'b0;
         perr_r  <= 1'b0;
         ferr_r  <= 1'b0;
         terr_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         perr_r <= 1'b0;
         ferr_r <= 1'b0;
         terr_r <= 1'b0;
         unique case (state)
            IDLE: begin
               if (fall_tick && rx.rx_en && !ps_d) begin
                  state   <= DATA;
                  bit_cnt <= 4'(FRAME_BITS - 1);
                  shreg   <= nxt_shreg;
                  wdog    <= '0;
               end
            end
            DATA: begin
               if (fall_tick) begin
                  shreg   <= nxt_shreg;
                  bit_cnt <= bit_cnt - 4'd1;
                  wdog    <= '0;
                  if (bit_cnt == 4'd1) begin
                     state <= CHECK;
                     if (!stop_bit)
                        ferr_r <= 1'b1;
                     else if (parity_bad)
                        perr_r <= 1'b1;
                     else begin
                        dout_r <= nxt_shreg[8:1];
                        done_r <= 1'b1;
                     end
                  end
               end else if (wdog == WD_MAX) begin
                  terr_r  <= 1'b1;
                  state   <= IDLE;
                  bit_cnt <= '0;
                  shreg   <= '0;
                  wdog    <= '0;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            CHECK: begin
               state   <= IDLE;
               bit_cnt <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rx.dout          = dout_r;
   assign rx.rx_done_tick  = done_r;
   assign rx.err_parity    = perr_r;
   assign rx.err_frame     = ferr_r;
   assign rx.err_timeout   = terr_r;
   assign rx.rx_busy       = (state != IDLE);
   assign rx.dbg.state     = state;
   assign rx.dbg.bit_cnt   = bit_cnt;
   assign rx.dbg.shreg     = shreg;

endmodule

// File: tb/tb_ps2_rx_checked.sv
// Directed bench for ps2_rx_checked: two instances share the PS/2 lines,
// u_dut with parity checking and u_dut_np with CHECK_PARITY=0.
module tb_ps2_rx_checked;
   import ps2_pkg::*;

   localparam int FL  = 8;
   localparam int TOC = 300;

   logic clk = 1'b0;
   logic reset;
   logic ps_c;
   logic ps_d;
   int   errors = 0;
   int   checks = 0;

   ps2_rx_checked_if rx1 ();
   ps2_rx_checked_if rx2 ();

   ps2_rx_checked #(.FILTER_LEN(FL), .TIMEOUT_CYC(TOC), .CHECK_PARITY(1)) u_dut (
      .clk(clk), .reset(reset), .ps_c(ps_c), .ps_d(ps_d), .rx(rx1.master)
   );

   ps2_rx_checked #(.FILTER_LEN(FL), .TIMEOUT_CYC(TOC), .CHECK_PARITY(0)) u_dut_np (
      .clk(clk), .reset(reset), .ps_c(ps_c), .ps_d(ps_d), .rx(rx2.master)
   );

   // clock / reset
   always #5 clk = ~clk;

   // driver tasks
   task automatic send_bit(input logic b);
      ps_d = b;
      repeat (10) @(negedge clk);
      ps_c = 1'b0;
      repeat (20) @(negedge clk);
      ps_c = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic glitch();
      ps_c = 1'b0;
      repeat (FL - 1) @(negedge clk);
      ps_c = 1'b1;
      repeat (FL + 4) @(negedge clk);
   endtask

   // Sends frame bits skip..10; the last falling edge is watched cycle by cycle.
   // lat = negedges after the last ps_c drop until the first pulse (-1: none).
   // pv/pv2 = {done, parity, frame, timeout} at the first pulse of each DUT.
   task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                             input int skip, output int lat, output logic [3:0] pv,
                             output int pcnt, output logic [3:0] pv2);
      logic [10:0] fr;
      logic [3:0]  cur;
      logic [3:0]  cur2;
      fr   = {stop, par, data, 1'b0};
      lat  = -1;
      pv   = '0;
      pv2  = '0;
      pcnt = 0;
      for (int i = skip; i < 10; i++) send_bit(fr[i]);
      ps_d = fr[10];
      repeat (10) @(negedge clk);
      ps_c = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         cur  = {rx1.rx_done_tick, rx1.err_parity, rx1.err_frame, rx1.err_timeout};
         cur2 = {rx2.rx_done_tick, rx2.err_parity, rx2.err_frame, rx2.err_timeout};
         if (cur != 4'b0000) begin
            pcnt++;
            if (lat < 0) begin
               lat = n;
               pv  = cur;
            end
         end
         if (cur2 != 4'b0000 && pv2 == 4'b0000) pv2 = cur2;
      end
      ps_c = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   // scenario tasks
   task automatic test_reset();
      reset = 1'b1;
      ps_c  = 1'b1;
      ps_d  = 1'b1;
      rx1.rx_en = 1'b1;
      rx2.rx_en = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (rx1.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", rx1.dout); end
      checks++;
      if ({rx1.rx_done_tick, rx1.err_parity, rx1.err_frame, rx1.err_timeout, rx1.rx_busy} !== 5'b0) begin
         errors++; $display("FAIL reset_pulses: got %b want 00000",
            {rx1.rx_done_tick, rx1.err_parity, rx1.err_frame, rx1.err_timeout, rx1.rx_busy});
      end
      checks++;
      if (rx1.dbg.state !== IDLE || rx1.dbg.bit_cnt !== 4'd0 || rx1.dbg.shreg !== 11'd0) begin
         errors++; $display("FAIL reset_fsm: got state=%0d cnt=%0d sh=%h want 0 0 000",
            rx1.dbg.state, rx1.dbg.bit_cnt, rx1.dbg.shreg);
      end
   endtask

   task automatic test_good_frame();
      int lat, pcnt;
      logic [3:0] pv, pv2;
      send_frame(8'h3C, 1'b1, 1'b1, 0, lat, pv, pcnt, pv2);
      checks++;
      if (pv !== 4'b1000) begin errors++; $display("FAIL good_pulse: got %b want 1000", pv); end
      checks++;
      if (lat !== FL + 1) begin errors++; $display("FAIL good_latency: got %0d want %0d", lat, FL + 1); end
      checks++;
      if (pcnt !== 1) begin errors++; $display("FAIL good_one_cycle: got %0d want 1", pcnt); end
      checks++;
      if (rx1.dout !== 8'h3C) begin errors++; $display("FAIL good_dout: got %h want 3c", rx1.dout); end
      checks++;
      if (rx1.rx_busy !== 1'b0) begin errors++; $display("FAIL good_idle: got busy=%b want 0", rx1.rx_busy); end
   endtask

   task automatic test_frame_err();
      int lat, pcnt;
      logic [3:0] pv, pv2;
      send_frame(8'hA5, 1'b1, 1'b0, 0, lat, pv, pcnt, pv2);
      checks++;
      if (pv !== 4'b0010 || lat !== FL + 1) begin
         errors++; $display("FAIL frame_err_pulse: got %b lat %0d want 0010 lat %0d", pv, lat, FL + 1);
      end
      checks++;
      if (rx1.dout !== 8'h3C) begin errors++; $display("FAIL frame_err_dout: got %h want 3c", rx1.dout); end
      send_frame(8'h5A, 1'b1, 1'b1, 0, lat, pv, pcnt, pv2);
      checks++;
      if (pv !== 4'b1000 || rx1.dout !== 8'h5A) begin
         errors++; $display("FAIL after_frame_err: got %b dout %h want 1000 dout 5a", pv, rx1.dout);
      end
   endtask

   task automatic test_parity();
      int lat, pcnt;
      logic [3:0] pv, pv2;
      send_frame(8'h3C, 1'b0, 1'b1, 0, lat, pv, pcnt, pv2);
      checks++;
      if (pv !== 4'b0100 || pcnt !== 1) begin
         errors++; $display("FAIL parity_pulse: got %b cnt %0d want 0100 cnt 1", pv, pcnt);
      end
      checks++;
      if (rx1.dout !== 8'h5A) begin errors++; $display("FAIL parity_dout: got %h want 5a", rx1.dout); end
      checks++;
      if (pv2 !== 4'b1000 || rx2.dout !== 8'h3C) begin
         errors++; $display("FAIL noparity_dut: got %b dout %h want 1000 dout 3c", pv2, rx2.dout);
      end
   endtask

   task automatic test_timeout();
      int lat, pcnt, seen;
      logic busy_at, other_at, next_to;
      logic [3:0] pv, pv2;
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      checks++;
      if (rx1.rx_busy !== 1'b1 || rx1.dbg.bit_cnt !== 4'd6) begin
         errors++; $display("FAIL timeout_partial: got busy=%b cnt=%0d want 1 6", rx1.rx_busy, rx1.dbg.bit_cnt);
      end
      seen = 0; busy_at = 1'b1; other_at = 1'b1; next_to = 1'b1;
      for (int n = 0; n < TOC + 100; n++) begin
         @(negedge clk);
         if (rx1.err_timeout === 1'b1) begin
            seen     = 1;
            busy_at  = rx1.rx_busy;
            other_at = rx1.rx_done_tick | rx1.err_parity | rx1.err_frame;
            @(negedge clk);
            next_to  = rx1.err_timeout;
            break;
         end
      end
      checks++;
      if (seen !== 1) begin errors++; $display("FAIL timeout_pulse: got none want one within %0d cycles", TOC + 100); end
      checks++;
      if (busy_at !== 1'b0 || other_at !== 1'b0 || next_to !== 1'b0) begin
         errors++; $display("FAIL timeout_state: got busy=%b other=%b next=%b want 0 0 0", busy_at, other_at, next_to);
      end
      checks++;
      if (rx1.dout !== 8'h5A || rx1.dbg.bit_cnt !== 4'd0) begin
         errors++; $display("FAIL timeout_discard: got dout %h cnt %0d want 5a 0", rx1.dout, rx1.dbg.bit_cnt);
      end
      send_frame(8'h12, 1'b1, 1'b1, 0, lat, pv, pcnt, pv2);
      checks++;
      if (pv !== 4'b1000 || rx1.dout !== 8'h12) begin
         errors++; $display("FAIL after_timeout: got %b dout %h want 1000 dout 12", pv, rx1.dout);
      end
   endtask

   task automatic test_glitch();
      int lat, pcnt;
      logic [3:0] pv, pv2;
      glitch();
      checks++;
      if (rx1.dbg.state !== IDLE || rx1.dbg.bit_cnt !== 4'd0) begin
         errors++; $display("FAIL glitch_idle: got state=%0d cnt=%0d want 0 0", rx1.dbg.state, rx1.dbg.bit_cnt);
      end
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      glitch();
      checks++;
      if (rx1.dbg.bit_cnt !== 4'd7) begin
         errors++; $display("FAIL glitch_data: got cnt=%0d want 7", rx1.dbg.bit_cnt);
      end
      send_frame(8'h81, 1'b1, 1'b1, 4, lat, pv, pcnt, pv2);
      checks++;
      if (pv !== 4'b1000 || rx1.dout !== 8'h81) begin
         errors++; $display("FAIL glitch_frame: got %b dout %h want 1000 dout 81", pv, rx1.dout);
      end
   endtask

   task automatic test_rx_en();
      int lat, pcnt;
      logic [3:0] pv, pv2;
      rx1.rx_en = 1'b0;
      rx2.rx_en = 1'b0;
      send_frame(8'h3C, 1'b1, 1'b1, 0, lat, pv, pcnt, pv2);
      checks++;
      if (pcnt !== 0 || rx1.dout !== 8'h81 || rx1.rx_busy !== 1'b0) begin
         errors++; $display("FAIL rx_en_ignore: got pulses=%0d dout %h busy %b want 0 81 0", pcnt, rx1.dout, rx1.rx_busy);
      end
      rx1.rx_en = 1'b1;
      rx2.rx_en = 1'b1;
      send_bit(1'b0);
      rx1.rx_en = 1'b0;
      rx2.rx_en = 1'b0;
      checks++;
      if (rx1.rx_busy !== 1'b1) begin errors++; $display("FAIL rx_en_start: got busy=%b want 1", rx1.rx_busy); end
      send_frame(8'hFF, 1'b1, 1'b1, 1, lat, pv, pcnt, pv2);
      checks++;
      if (pv !== 4'b1000 || rx1.dout !== 8'hFF) begin
         errors++; $display("FAIL rx_en_drop: got %b dout %h want 1000 dout ff", pv, rx1.dout);
      end
      rx1.rx_en = 1'b1;
      rx2.rx_en = 1'b1;
   endtask

   task automatic test_reset_mid_frame();
      int lat, pcnt;
      logic [3:0] pv, pv2;
      logic any_pulse;
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      reset = 1'b1;
      any_pulse = 1'b0;
      repeat (2) begin
         @(negedge clk);
         any_pulse = any_pulse | rx1.rx_done_tick | rx1.err_parity | rx1.err_frame | rx1.err_timeout;
      end
      reset = 1'b0;
      @(negedge clk);
      any_pulse = any_pulse | rx1.rx_done_tick | rx1.err_parity | rx1.err_frame | rx1.err_timeout;
      checks++;
      if (any_pulse !== 1'b0 || rx1.rx_busy !== 1'b0 || rx1.dout !== 8'h00) begin
         errors++; $display("FAIL reset_mid: got pulse=%b busy=%b dout %h want 0 0 00", any_pulse, rx1.rx_busy, rx1.dout);
      end
      send_frame(8'h66, 1'b1, 1'b1, 0, lat, pv, pcnt, pv2);
      checks++;
      if (pv !== 4'b1000 || rx1.dout !== 8'h66) begin
         errors++; $display("FAIL after_reset: got %b dout %h want 1000 dout 66", pv, rx1.dout);
      end
   endtask

   // sequence and final report
   initial begin
      test_reset();
      test_good_frame();
      test_frame_err();
      test_parity();
      test_timeout();
      test_glitch();
      test_rx_en();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // hard stop so the run always ends
   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: got time limit want completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_rx_checked.md
PS2_RX_CHECKED -- requirements
Module: ps2_rx_checked

Interface
REQ-001 Parameter FILTER_LEN, default 8: length of the ps_c glitch filter in clk cycles, range 2..16.
REQ-002 Parameter TIMEOUT_CYC, default 100000: clk cycles allowed between falling edges inside a frame (2 ms at 50 MHz).
REQ-003 Parameter CHECK_PARITY, default 1: 1 enables the odd-parity check; 0 ignores the parity bit.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rx_en  input  1  permits the start of a new frame; sampled only in IDLE.
REQ-007 ps_c  input  1  PS/2 clock line, asynchronous to clk.
REQ-008 ps_d  input  1  PS/2 data line, asynchronous to clk.
REQ-009 dout  output  8  last correctly received data byte.
REQ-010 rx_done_tick  output  1  one-cycle pulse when dout has been updated with a good frame.
REQ-011 err_parity  output  1  one-cycle pulse: parity failure.
REQ-012 err_frame  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-013 err_timeout  output  1  one-cycle pulse: frame abandoned on timeout.
REQ-014 rx_busy  output  1  high in any state other than IDLE.

Function
REQ-015 ps_c SHALL pass through a FILTER_LEN-bit shift register; the filtered clock becomes 1 when all bits are 1, becomes 0 when all bits are 0, and otherwise holds.
REQ-016 A fall tick SHALL be asserted for exactly the cycle in which the filtered clock changes from 1 to 0; ps_d is sampled in that same cycle.
REQ-017 Frame format: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1; 11 fall ticks per frame.
REQ-018 States: IDLE, DATA, CHECK.
REQ-019 IDLE: on fall tick with rx_en=1 and ps_d=0 -> DATA, bit counter = 10 remaining; fall tick with ps_d=1 or rx_en=0 is ignored, state stays IDLE.
REQ-020 DATA: each fall tick shifts ps_d into an 11-bit register from the MSB side and decrements the counter; the tick that consumes the last remaining bit -> CHECK.
REQ-021 CHECK lasts exactly one cycle, then -> IDLE unconditionally.
REQ-022 In CHECK, with the stop bit at 0: err_frame=1 and no other pulse.
REQ-023 In CHECK, with the stop bit at 1, CHECK_PARITY=1, and XOR of the 8 data bits and the parity bit equal to 0: err_parity=1.
REQ-024 In CHECK, otherwise: dout is loaded and rx_done_tick=1 in the same cycle; dout is unchanged on any error.
REQ-025 Latency: rx_done_tick or error pulse SHALL occur the cycle after the 11th fall tick.
REQ-026 In DATA, a watchdog counter clears on every fall tick and increments otherwise.
REQ-027 If the watchdog reaches TIMEOUT_CYC-1 in DATA: err_timeout=1 for one cycle, -> IDLE, bit counter cleared, partial data discarded.
REQ-028 The watchdog width is ceil(log2(TIMEOUT_CYC)) bits and never wraps.
REQ-029 rx_en deasserting mid-frame SHALL NOT abort the frame.
REQ-030 At most one of rx_done_tick/err_parity/err_frame/err_timeout is high in any cycle.

Reset
REQ-031 Reset SHALL force: state IDLE, filter register all ones, filtered clock 1, shift register 0, bit counter 0, watchdog 0, dout 0x00, all pulses 0, rx_busy 0.
REQ-032 Reset mid-frame discards the frame with no pulse; the first valid start is accepted after reset deasserts.

Structure
REQ-033 Shared package ps2_pkg holds the state encoding, FRAME_BITS=11, and DATA_BITS=8.
REQ-034 Sub-module ps2_clk_filter contains the filter and fall-tick generation, parameterised by FILTER_LEN.

Verification
REQ-035 Frame 0x3C, parity 1, stop 1, rx_en=1 -> dout=0x3C, rx_done_tick one cycle after the 11th fall, no error.
REQ-036 Frame 0x3C with parity 0 -> err_parity pulse, dout holds its previous value; with CHECK_PARITY=0 -> rx_done_tick, dout=0x3C.
REQ-037 Frame 0xA5 with stop 0 -> err_frame pulse only; the next good frame 0x5A -> dout=0x5A.
REQ-038 5 bits sent, then ps_c held high for TIMEOUT_CYC cycles -> err_timeout pulse, rx_busy=0; the following frame 0x12 is received correctly.
REQ-039 ps_c low glitch of FILTER_LEN-1 cycles in IDLE and DATA -> no fall tick, bit count unchanged.
REQ-040 Start bit with rx_en=0 -> frame ignored; rx_en dropped after start -> frame 0xFF completes.
